// File: rtl/vid_timing_pkg.sv
// Shared timing constants and helpers for the SMC-777 raster timing generator.
//
// Contents:
//   SMC_* constants  default SMC-777 horizontal and NTSC/PAL vertical timing
//   vval_t           working width for vertical threshold arithmetic
//   v_timing_t       one set of vertical thresholds (total/active/sync start/end)
//   v_scale()        doubles a vertical value when line doubling is in effect
//   v_timing_scale() applies v_scale() to every field of a v_timing_t
package vid_timing_pkg;

    localparam int unsigned SMC_CE_DIV  = 2;

    localparam int unsigned SMC_H_TOT   = 638;
    localparam int unsigned SMC_H_ACT   = 529;
    localparam int unsigned SMC_H_SS    = 544;
    localparam int unsigned SMC_H_SE    = 590;

    localparam int unsigned SMC_V_TOT_N = 262;
    localparam int unsigned SMC_V_ACT_N = 240;
    localparam int unsigned SMC_V_SS_N  = 245;
    localparam int unsigned SMC_V_SE_N  = 248;

    localparam int unsigned SMC_V_TOT_P = 312;
    localparam int unsigned SMC_V_ACT_P = 300;
    localparam int unsigned SMC_V_SS_P  = 304;
    localparam int unsigned SMC_V_SE_P  = 308;

    // Wide enough for any doubled line count this core can use.
    localparam int unsigned V_CALC_W = 16;

    typedef logic [V_CALC_W-1:0] vval_t;

    typedef struct packed {
        vval_t tot;
        vval_t act;
        vval_t ss;
        vval_t se;
    } v_timing_t;

    // Line doubling is a plain left shift of every vertical value.
    function automatic vval_t v_scale(input vval_t value, input logic sd);
        return sd ? vval_t'(value << 1) : value;
    endfunction

    function automatic v_timing_t v_timing_scale(input v_timing_t t, input logic sd);
        v_timing_t r;
        r.tot = v_scale(t.tot, sd);
        r.act = v_scale(t.act, sd);
        r.ss  = v_scale(t.ss,  sd);
        r.se  = v_scale(t.se,  sd);
        return r;
    endfunction

endpackage

// File: rtl/pix_ce_gen.sv
// Pixel clock-enable divider.
//
// Produces a one-clk ce_pix pulse every P clocks, where P = CE_DIV at single
// line rate and CE_DIV/2 when line doubling is in effect. With P = 1 the
// enable is held high continuously once out of reset.
//
// Ports:
//   clk     in   system clock
//   reset   in   synchronous, active-high
//   sd      in   latched scandouble (selects the divide ratio)
//   ce_pix  out  pixel clock enable
module pix_ce_gen #(
    parameter int unsigned CE_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sd,
    output logic ce_pix
);

    localparam int unsigned CW = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_eff;
    logic [CW-1:0] last;
    logic          sd_prev;

    // A ratio change restarts the divider from zero so the first period in
    // the new mode is a full one: no extra or dropped enable at the switch.
    always_comb begin
        last    = sd ? CW'(CE_DIV / 2 - 1) : CW'(CE_DIV - 1);
        cnt_eff = (sd != sd_prev) ? '0 : cnt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            ce_pix  <= 1'b0;
            sd_prev <= sd;
        end else begin
            ce_pix  <= (cnt_eff == last);
            cnt     <= (cnt_eff == last) ? '0 : cnt_eff + CW'(1);
            sd_prev <= sd;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator for the SMC-777 core.
//
// Generates the pixel enable, raster counters, blanking, sync and pixel
// coordinates for NTSC/PAL at single or doubled line rate. The requested mode
// (pal/scandouble) is latched only at the end of a frame so a frame is never
// split between two timings.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high
//   pal          in   requested mode: 1 = PAL, 0 = NTSC
//   scandouble   in   requested line doubling
//   ce_pix       out  pixel clock enable
//   hc, vc       out  horizontal / vertical counters
//   x, y         out  active column / source line, 0 outside the active area
//   de           out  data enable (neither blank active)
//   hblank       out  horizontal blank
//   vblank       out  vertical blank
//   hsync        out  horizontal sync, HS_POL-active
//   vsync        out  vertical sync, VS_POL-active
//   line_start   out  one-clk pulse with hc = 0 after each line wrap
//   frame_start  out  one-clk pulse with hc = vc = 0 after each frame wrap
//   frame_cnt    out  completed frames, wrapping
//   pal_l, sd_l  out  mode currently in effect
module video_timing_gen
    import vid_timing_pkg::*;
#(
    parameter int unsigned CE_DIV  = SMC_CE_DIV,
    parameter int unsigned HW      = 10,
    parameter int unsigned VW      = 10,
    parameter int unsigned H_TOT   = SMC_H_TOT,
    parameter int unsigned H_ACT   = SMC_H_ACT,
    parameter int unsigned H_SS    = SMC_H_SS,
    parameter int unsigned H_SE    = SMC_H_SE,
    parameter int unsigned V_TOT_N = SMC_V_TOT_N,
    parameter int unsigned V_ACT_N = SMC_V_ACT_N,
    parameter int unsigned V_SS_N  = SMC_V_SS_N,
    parameter int unsigned V_SE_N  = SMC_V_SE_N,
    parameter int unsigned V_TOT_P = SMC_V_TOT_P,
    parameter int unsigned V_ACT_P = SMC_V_ACT_P,
    parameter int unsigned V_SS_P  = SMC_V_SS_P,
    parameter int unsigned V_SE_P  = SMC_V_SE_P,
    parameter logic        HS_POL  = 1'b1,
    parameter logic        VS_POL  = 1'b1,
    parameter int unsigned FRAME_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pal,
    input  logic               scandouble,
    output logic               ce_pix,
    output logic [HW-1:0]      hc,
    output logic [VW-1:0]      vc,
    output logic [HW-1:0]      x,
    output logic [VW-1:0]      y,
    output logic               de,
    output logic               hblank,
    output logic               vblank,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               pal_l,
    output logic               sd_l
);

    localparam v_timing_t V_NTSC = '{
        tot: vval_t'(V_TOT_N), act: vval_t'(V_ACT_N),
        ss:  vval_t'(V_SS_N),  se:  vval_t'(V_SE_N)
    };
    localparam v_timing_t V_PAL = '{
        tot: vval_t'(V_TOT_P), act: vval_t'(V_ACT_P),
        ss:  vval_t'(V_SS_P),  se:  vval_t'(V_SE_P)
    };

    localparam logic [HW-1:0] H_LAST_V = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT_V  = HW'(H_ACT);
    localparam logic [HW-1:0] H_SS_V   = HW'(H_SS);
    localparam logic [HW-1:0] H_SE_V   = HW'(H_SE);

    v_timing_t     v_cur;
    logic [VW-1:0] v_last;
    logic [VW-1:0] v_act;
    logic [VW-1:0] v_ss;
    logic [VW-1:0] v_se;
    logic          h_wrap;
    logic          v_wrap;

    pix_ce_gen #(
        .CE_DIV (CE_DIV)
    ) u_pix_ce_gen (
        .clk    (clk),
        .reset  (reset),
        .sd     (sd_l),
        .ce_pix (ce_pix)
    );

    // Vertical thresholds always follow the latched mode, never the inputs.
    always_comb begin
        v_cur  = v_timing_scale(pal_l ? V_PAL : V_NTSC, sd_l);
        v_last = VW'(v_cur.tot - vval_t'(1));
        v_act  = VW'(v_cur.act);
        v_ss   = VW'(v_cur.ss);
        v_se   = VW'(v_cur.se);
        h_wrap = (hc == H_LAST_V);
        v_wrap = h_wrap && (vc == v_last);
    end

    assign x  = (hc < H_ACT_V) ? hc : '0;
    assign y  = (vc < v_act) ? (vc >> sd_l) : '0;
    assign de = ~hblank & ~vblank;

    // Flags are decoded from the counter value that the current ce consumes,
    // so they appear together with the following counter value.
    always_ff @(posedge clk) begin
        if (reset) begin
            hc          <= '0;
            vc          <= '0;
            frame_cnt   <= '0;
            hblank      <= 1'b0;
            vblank      <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            pal_l       <= pal;
            sd_l        <= scandouble;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (ce_pix) begin
                if (h_wrap) begin
                    hc         <= '0;
                    line_start <= 1'b1;
                    if (v_wrap) begin
                        vc          <= '0;
                        frame_start <= 1'b1;
                        frame_cnt   <= frame_cnt + FRAME_W'(1);
                        pal_l       <= pal;
                        sd_l        <= scandouble;
                    end else begin
                        vc <= vc + VW'(1);
                    end
                end else begin
                    hc <= hc + HW'(1);
                end

                if (hc == H_ACT_V) begin
                    hblank <= 1'b1;
                end else if (hc == '0) begin
                    hblank <= 1'b0;
                end

                if (hc == H_SS_V) begin
                    hsync <= HS_POL;
                end else if (hc == H_SE_V) begin
                    hsync <= ~HS_POL;
                end

                // Vertical flags move only at the hsync leading edge.
                if (hc == H_SS_V) begin
                    if (vc == v_act) begin
                        vblank <= 1'b1;
                    end else if (vc == '0) begin
                        vblank <= 1'b0;
                    end

                    if (vc == v_ss) begin
                        vsync <= VS_POL;
                    end else if (vc == v_se) begin
                        vsync <= ~VS_POL;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen using a shrunken raster:
//   H: tot 40, act 30, sync 32..36
//   NTSC: 10 lines, act 6, sync 7..9     PAL: 12 lines, act 8, sync 9..11
//   hsync active high, vsync active low, 4-bit frame counter.
module tb_video_timing_gen;

    localparam logic HS_ACT = 1'b1;
    localparam logic VS_ACT = 1'b0;

    logic       clk = 1'b0;
    logic       reset;
    logic       pal;
    logic       scandouble;
    logic       ce_pix;
    logic [9:0] hc;
    logic [9:0] vc;
    logic [9:0] x;
    logic [9:0] y;
    logic       de;
    logic       hblank;
    logic       vblank;
    logic       hsync;
    logic       vsync;
    logic       line_start;
    logic       frame_start;
    logic [3:0] frame_cnt;
    logic       pal_l;
    logic       sd_l;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    int unsigned m_ces, m_clks, m_lines, m_hb, m_hs, m_vs, m_vb;
    int unsigned m_hb_hc, m_vb_hc, m_vb_vc, m_vs_hc, m_vs_vc;

    video_timing_gen #(
        .CE_DIV  (2),
        .HW      (10),
        .VW      (10),
        .H_TOT   (40),
        .H_ACT   (30),
        .H_SS    (32),
        .H_SE    (36),
        .V_TOT_N (10),
        .V_ACT_N (6),
        .V_SS_N  (7),
        .V_SE_N  (9),
        .V_TOT_P (12),
        .V_ACT_P (8),
        .V_SS_P  (9),
        .V_SE_P  (11),
        .HS_POL  (HS_ACT),
        .VS_POL  (VS_ACT),
        .FRAME_W (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pal         (pal),
        .scandouble  (scandouble),
        .ce_pix      (ce_pix),
        .hc          (hc),
        .vc          (vc),
        .x           (x),
        .y           (y),
        .de          (de),
        .hblank      (hblank),
        .vblank      (vblank),
        .hsync       (hsync),
        .vsync       (vsync),
        .line_start  (line_start),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt),
        .pal_l       (pal_l),
        .sd_l        (sd_l)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic p, input logic s, input int unsigned clks);
        reset      = 1'b1;
        pal        = p;
        scandouble = s;
        repeat (clks) step();
    endtask

    task automatic wait_fs(input string tag, input int unsigned limit);
        int unsigned n;
        logic hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < limit) begin
            step();
            n++;
            hit = frame_start;
        end
        check({tag, "_reached"}, 32'(hit), 1);
    endtask

    task automatic wait_pos(input string tag, input int unsigned h, input int unsigned v,
                            input int unsigned limit);
        int unsigned n;
        logic hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < limit) begin
            step();
            n++;
            hit = ce_pix && (32'(hc) == h) && (32'(vc) == v);
        end
        check({tag, "_reached"}, 32'(hit), 1);
    endtask

    // Called on a frame_start cycle; returns on the next one.
    task automatic measure_frame(input string tag);
        int unsigned n;
        logic done, hb_p, vb_p, vs_p, hb_seen, vb_seen, vs_seen;
        m_ces = 0; m_clks = 0; m_lines = 0; m_hb = 0; m_hs = 0; m_vs = 0; m_vb = 0;
        m_hb_hc = 0; m_vb_hc = 0; m_vb_vc = 0; m_vs_hc = 0; m_vs_vc = 0;
        hb_seen = 1'b0; vb_seen = 1'b0; vs_seen = 1'b0;
        hb_p = hblank;
        vb_p = vblank;
        vs_p = (vsync == VS_ACT);
        done = 1'b0;
        n    = 0;
        while (!done && n < 4000) begin
            m_clks++;
            if (ce_pix) begin
                m_ces++;
                if (hblank) m_hb++;
                if (vblank) m_vb++;
                if (hsync == HS_ACT) m_hs++;
                if (vsync == VS_ACT) m_vs++;
            end
            if (line_start) m_lines++;
            if (hblank && !hb_p && !hb_seen) begin
                hb_seen = 1'b1; m_hb_hc = 32'(hc);
            end
            if (vblank && !vb_p && !vb_seen) begin
                vb_seen = 1'b1; m_vb_hc = 32'(hc); m_vb_vc = 32'(vc);
            end
            if ((vsync == VS_ACT) && !vs_p && !vs_seen) begin
                vs_seen = 1'b1; m_vs_hc = 32'(hc); m_vs_vc = 32'(vc);
            end
            hb_p = hblank;
            vb_p = vblank;
            vs_p = (vsync == VS_ACT);
            step();
            n++;
            done = frame_start;
        end
        check({tag, "_frame_end"}, 32'(done), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---- reset, NTSC single rate ----
        do_reset(1'b0, 1'b0, 3);
        check("rst_ce",     32'(ce_pix),      0);
        check("rst_hc",     32'(hc),          0);
        check("rst_vc",     32'(vc),          0);
        check("rst_x",      32'(x),           0);
        check("rst_y",      32'(y),           0);
        check("rst_hblank", 32'(hblank),      0);
        check("rst_vblank", 32'(vblank),      0);
        check("rst_de",     32'(de),          1);
        check("rst_hsync",  32'(hsync),       0);
        check("rst_vsync",  32'(vsync),       1);
        check("rst_ls",     32'(line_start),  0);
        check("rst_fs",     32'(frame_start), 0);
        check("rst_fcnt",   32'(frame_cnt),   0);
        check("rst_pal_l",  32'(pal_l),       0);
        check("rst_sd_l",   32'(sd_l),        0);
        reset = 1'b0;
        step(); check("ce_seq0", 32'(ce_pix), 0); check("hc_seq0", 32'(hc), 0);
        step(); check("ce_seq1", 32'(ce_pix), 1); check("hc_seq1", 32'(hc), 0);
        step(); check("ce_seq2", 32'(ce_pix), 0); check("hc_seq2", 32'(hc), 1);
        step(); check("ce_seq3", 32'(ce_pix), 1); check("hc_seq3", 32'(hc), 1);

        // ---- NTSC single-rate frame ----
        wait_fs("ntsc_fs", 1000);
        measure_frame("ntsc");
        check("ntsc_ces",    m_ces,   400);
        check("ntsc_clks",   m_clks,  800);
        check("ntsc_lines",  m_lines, 10);
        check("ntsc_hb_cnt", m_hb,    100);
        check("ntsc_hs_cnt", m_hs,    40);
        check("ntsc_vs_cnt", m_vs,    80);
        check("ntsc_vb_cnt", m_vb,    160);
        check("ntsc_hb_hc",  m_hb_hc, 31);
        check("ntsc_vb_hc",  m_vb_hc, 33);
        check("ntsc_vb_vc",  m_vb_vc, 6);
        check("ntsc_vs_hc",  m_vs_hc, 33);
        check("ntsc_vs_vc",  m_vs_vc, 7);
        wait_pos("ntsc_p1", 5, 2, 1000);
        check("ntsc_p1_x", 32'(x), 5); check("ntsc_p1_y", 32'(y), 2); check("ntsc_p1_de", 32'(de), 1);
        wait_pos("ntsc_p2", 35, 2, 1000);
        check("ntsc_p2_x", 32'(x), 0); check("ntsc_p2_y", 32'(y), 2); check("ntsc_p2_de", 32'(de), 0);
        wait_pos("ntsc_p3", 5, 7, 1000);
        check("ntsc_p3_x", 32'(x), 5); check("ntsc_p3_y", 32'(y), 0); check("ntsc_p3_de", 32'(de), 0);

        // ---- PAL line-doubled from reset ----
        do_reset(1'b1, 1'b1, 3);
        check("pd_rst_pal_l", 32'(pal_l), 1);
        check("pd_rst_sd_l",  32'(sd_l),  1);
        reset = 1'b0;
        begin
            int unsigned ones;
            ones = 0;
            for (int i = 0; i < 20; i++) begin
                step();
                if (ce_pix) ones++;
            end
            check("pd_ce_const", ones, 20);
        end
        wait_fs("pd_fs", 2000);
        measure_frame("pd");
        check("pd_ces",    m_ces,   960);
        check("pd_clks",   m_clks,  960);
        check("pd_lines",  m_lines, 24);
        check("pd_hb_cnt", m_hb,    240);
        check("pd_hs_cnt", m_hs,    96);
        check("pd_vs_cnt", m_vs,    160);
        check("pd_vb_cnt", m_vb,    320);
        check("pd_vb_hc",  m_vb_hc, 33);
        check("pd_vb_vc",  m_vb_vc, 16);
        check("pd_vs_hc",  m_vs_hc, 33);
        check("pd_vs_vc",  m_vs_vc, 18);
        wait_pos("pd_p1", 3, 5, 2000);
        check("pd_p1_x", 32'(x), 3); check("pd_p1_y", 32'(y), 2);

        // ---- pal request mid-frame ----
        do_reset(1'b0, 1'b0, 3);
        reset = 1'b0;
        wait_pos("pal_req", 0, 3, 1000);
        pal = 1'b1;
        wait_pos("pal_last", 39, 9, 1000);
        check("pal_hold", 32'(pal_l), 0);
        step();
        check("pal_fs",  32'(frame_start), 1);
        check("pal_new", 32'(pal_l),       1);
        measure_frame("pal");
        check("pal_lines", m_lines, 12);
        check("pal_ces",   m_ces,   480);
        check("pal_clks",  m_clks,  960);

        // ---- scandouble 0 -> 1 mid-frame ----
        wait_pos("sd1_req", 0, 4, 1000);
        scandouble = 1'b1;
        wait_pos("sd1_last", 39, 11, 1000);
        check("sd1_hold", 32'(sd_l), 0);
        step();
        check("sd1_f0_fs", 32'(frame_start), 1); check("sd1_f0_sd", 32'(sd_l), 1);
        check("sd1_f0_ce", 32'(ce_pix), 0);      check("sd1_f0_hc", 32'(hc), 0);
        step(); check("sd1_f1_ce", 32'(ce_pix), 1); check("sd1_f1_hc", 32'(hc), 0);
        step(); check("sd1_f2_ce", 32'(ce_pix), 1); check("sd1_f2_hc", 32'(hc), 1);
        step(); check("sd1_f3_ce", 32'(ce_pix), 1); check("sd1_f3_hc", 32'(hc), 2);
        wait_fs("sd1_fs", 2000);
        measure_frame("sd1");
        check("sd1_ces",  m_ces,  960);
        check("sd1_clks", m_clks, 960);

        // ---- scandouble 1 -> 0 mid-frame ----
        wait_pos("sd0_req", 0, 10, 2000);
        scandouble = 1'b0;
        wait_pos("sd0_last", 39, 23, 2000);
        check("sd0_hold", 32'(sd_l), 1);
        step();
        check("sd0_f0_fs", 32'(frame_start), 1); check("sd0_f0_sd", 32'(sd_l), 0);
        check("sd0_f0_ce", 32'(ce_pix), 1);      check("sd0_f0_hc", 32'(hc), 0);
        step(); check("sd0_f1_ce", 32'(ce_pix), 0); check("sd0_f1_hc", 32'(hc), 1);
        step(); check("sd0_f2_ce", 32'(ce_pix), 1); check("sd0_f2_hc", 32'(hc), 1);
        step(); check("sd0_f3_ce", 32'(ce_pix), 0); check("sd0_f3_hc", 32'(hc), 2);
        wait_fs("sd0_fs", 2000);
        measure_frame("sd0");
        check("sd0_ces",  m_ces,  480);
        check("sd0_clks", m_clks, 960);

        // ---- frame counter wrap ----
        do_reset(1'b0, 1'b0, 3);
        reset = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            wait_fs("fc_fs", 1000);
            check("fc_val", 32'(frame_cnt), 32'(k % 16));
        end

        // ---- reset mid-frame ----
        wait_pos("mr_pos", 35, 7, 1000);
        check("mr_pre_hblank", 32'(hblank), 1);
        check("mr_pre_vblank", 32'(vblank), 1);
        check("mr_pre_hsync",  32'(hsync),  1);
        check("mr_pre_vsync",  32'(vsync),  0);
        check("mr_pre_fcnt",   32'(frame_cnt), 1);
        reset = 1'b1;
        step();
        check("mr_hc",     32'(hc),        0);
        check("mr_vc",     32'(vc),        0);
        check("mr_fcnt",   32'(frame_cnt), 0);
        check("mr_ce",     32'(ce_pix),    0);
        check("mr_hblank", 32'(hblank),    0);
        check("mr_vblank", 32'(vblank),    0);
        check("mr_hsync",  32'(hsync),     0);
        check("mr_vsync",  32'(vsync),     1);
        check("mr_x",      32'(x),         0);
        reset = 1'b0;
        wait_fs("mr_fs", 1000);
        check("mr_fcnt_after", 32'(frame_cnt), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Parametrised raster timing generator for the SMC-777 core. It produces the pixel clock enable, counters, blanking, sync and pixel coordinates for NTSC/PAL at single or doubled line rate. Timing values come from parameters instead of hard-coded literals, and sync polarity is configurable. A mode change on pal/scandouble takes effect only at a frame boundary. The block feeds the video shifter, the VRAM fetch logic and the MiSTer video output.

Parameters:
CE_DIV, 2, clk cycles per pixel at single rate; must be even and ≥2; the scandouble period is CE_DIV/2
HW, 10, horizontal counter width
VW, 10, vertical counter width; must hold 2*V_TOT_P-1
H_TOT, 638, pixels per line
H_ACT, 529, active pixels; hblank starts at hc==H_ACT
H_SS, 544, hsync start pixel
H_SE, 590, hsync end pixel
V_TOT_N / V_ACT_N / V_SS_N / V_SE_N, 262/240/245/248, NTSC lines, single rate
V_TOT_P / V_ACT_P / V_SS_P / V_SE_P, 312/300/304/308, PAL lines, single rate
HS_POL, 1, active level of hsync
VS_POL, 1, active level of vsync
FRAME_W, 8, frame counter width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
pal  in  1  requested mode: 1=PAL, 0=NTSC
scandouble  in  1  requested line doubling
ce_pix  out  1  pixel clock enable
hc  out  HW  horizontal counter
vc  out  VW  vertical counter
x  out  HW  active pixel column (=hc while hc<H_ACT, else 0)
y  out  VW  source line (=vc>>sd_l while active, else 0)
de  out  1  data enable = ~hblank & ~vblank
hblank  out  1  horizontal blank
vblank  out  1  vertical blank
hsync  out  1  horizontal sync, HS_POL-active
vsync  out  1  vertical sync, VS_POL-active
line_start  out  1  one-clk pulse on the ce where hc wraps to 0
frame_start  out  1  one-clk pulse on the ce where hc and vc both wrap to 0
frame_cnt  out  FRAME_W  frames completed, wraps
pal_l  out  1  latched mode in effect
sd_l  out  1  latched scandouble in effect

Behaviour:
- Reset values: ce_pix=0, hc=vc=0, frame_cnt=0, hblank=vblank=0, hsync=~HS_POL, vsync=~VS_POL, line_start=frame_start=0, x=y=0. pal_l/sd_l load pal/scandouble during reset.
- ce generator: div counter runs 0..P-1, where P=sd_l?CE_DIV/2:CE_DIV. ce_pix=1 on the clk where the counter reaches P-1. With P=1, ce_pix is constant 1 after reset. The counter clears whenever sd_l changes.
- Counters advance only on ce_pix:
  - hc increments and wraps H_TOT-1→0.
  - On hc wrap, vc increments and wraps VT-1→0.
  - VT = sd_l ? 2*V_TOT_x : V_TOT_x, where x is selected by pal_l.
  - All V thresholds are doubled when sd_l=1.
- Mode latch: pal_l/sd_l update from the inputs only on the ce where hc==H_TOT-1 and vc==VT-1, or during reset. Input changes mid-frame are ignored until then.
- Sync and blank outputs are registered on the ce_pix cycle that decodes the current hc/vc. They are therefore one pixel later than the counter value.
  - hblank: set at hc==H_ACT, cleared at hc==0.
  - hsync: active from hc==H_SS to hc==H_SE.
- Vertical flags (vblank, vsync) change only on the ce where hc==H_SS.
  - vblank: set when vc==V_ACT, cleared when vc==0.
  - vsync: active when vc==V_SS, inactive when vc==V_SE.
- line_start, frame_start: single-clk pulses aligned with the ce that performs the wrap. frame_cnt increments in the same cycle.
- frame_cnt wraps 2^FRAME_W-1→0 with no flag.
- Reset mid-frame returns every output to its reset value on the next clk. Counting restarts at hc=vc=0 with no partial frame counted.
- Widths: all comparisons are unsigned at HW/VW. Doubling is a left shift; parameters must fit.

Decomposition:
- Package vid_timing_pkg holds:
  - default SMC-777 timing constants (NTSC/PAL, H set);
  - a helper function v_scale(value, sd) returning the doubled value.
- Sub-module pix_ce_gen contains the ce divider, taking the latched sd as input.
- The counters, mode latch and decode stay in video_timing_gen.

Test Plan:
- Reset with pal=0, scandouble=0, held for 3 clks, then released → all outputs at reset values. ce_pix alternates 0,1 starting on the first clk after release. hc=1 after the first ce.
- NTSC single rate, one full frame → exactly 638*262 ce pulses between frame_start pulses. hblank rises the ce after hc=529. hsync is active for 46 pixels (hc 544..589). vsync is active on lines 245..247.
- pal=1, scandouble=1 from reset → ce_pix is constant 1. The frame is 624 lines. vblank rises at vc=600, hc=544. vsync is active over vc 608..615.
- Toggle pal 0→1 at vc=100 → pal_l stays 0 until the NTSC frame completes (vc=261, hc=637 ce). The next frame is 312 lines.
- Toggle scandouble mid-frame → the ce period changes only after frame_start. The div counter restarts cleanly with no double or missing ce.
- Run 256 frames → frame_cnt goes 255→0 on the 256th frame_start. Assert reset at hc=300, vc=100 → the next clk shows hc=vc=0 and frame_cnt=0.
